mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_cpu_pkg.sv | 58 +++++
 rtl/mc_ctrl_decode.sv | 108 ++++++++++
 rtl/mc_control_unit.sv | 79 +++++++
 3 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes, ALU and next-PC selects.
// MC_CTRL_HALT_EN adds the HALT state and the HALT opcode decode.
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100
`ifdef MC_CTRL_HALT_EN
    , S_HALT = 3'b111
`endif
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT
  } op_class_t;

  // Anything not listed falls through as a NOP; HALT only exists when the feature is built.
  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND: c = C_RTYPE;
      OP_ADDI: c = C_ADDI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_J:    c = C_J;
`ifdef MC_CTRL_HALT_EN
      OP_HALT: c = C_HALT;
`endif
      default: c = C_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: next state and datapath controls from current state, opcode and zero.
// MC_CTRL_HALT_EN enables the HALT state transitions.
module mc_ctrl_decode
  import mc_cpu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_t         cur_state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output state_t         next_state,
  output logic           pcwre,
  output logic           irwre,
  output logic [1:0]     pcsrc,
  output logic           alusrcb,
  output logic [2:0]     aluop,
  output logic           regwre,
  output logic           regdst,
  output logic           memrd,
  output logic           memwr,
  output logic           dbdatasrc
);

  logic [5:0] op6;
  op_class_t  cls;

  assign op6 = 6'(opcode);
  assign cls = classify(op6);

  always_comb begin
    next_state = S_IF;
    pcwre      = 1'b0;
    irwre      = 1'b0;
    pcsrc      = PC_INC;
    alusrcb    = 1'b0;
    aluop      = ALU_ADD;
    regwre     = 1'b0;
    regdst     = 1'b0;
    memrd      = 1'b0;
    memwr      = 1'b0;
    dbdatasrc  = 1'b0;

    // ALU function follows the opcode in every state; only EXE makes use of it.
    if (cls == C_BEQ || op6 == OP_SUB) aluop = ALU_SUB;
    else if (op6 == OP_OR)             aluop = ALU_OR;
    else if (op6 == OP_AND)            aluop = ALU_AND;

    case (cur_state)
      S_IF: begin
        irwre      = 1'b1;
        next_state = S_ID;
      end
      S_ID: begin
        case (cls)
          C_J: begin
            pcwre      = 1'b1;
            pcsrc      = PC_JMP;
            next_state = S_IF;
          end
          C_NOP: begin
            pcwre      = 1'b1;
            next_state = S_IF;
          end
`ifdef MC_CTRL_HALT_EN
          C_HALT: next_state = S_HALT;
`endif
          default: next_state = S_EXE;
        endcase
      end
      S_EXE: begin
        alusrcb = (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);
        if (cls == C_BEQ) begin
          pcwre      = 1'b1;
          pcsrc      = zero ? PC_BR : PC_INC;
          next_state = S_IF;
        end else if (cls == C_LW || cls == C_SW) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        if (cls == C_SW) begin
          memwr      = 1'b1;
          pcwre      = 1'b1;
          next_state = S_IF;
        end else begin
          memrd      = 1'b1;
          dbdatasrc  = 1'b1;
          next_state = S_WB;
        end
      end
      S_WB: begin
        pcwre      = 1'b1;
        regwre     = 1'b1;
        regdst     = (cls == C_RTYPE);
        memrd      = (cls == C_LW);
        dbdatasrc  = (cls == C_LW);
        next_state = S_IF;
      end
`ifdef MC_CTRL_HALT_EN
      S_HALT: next_state = S_HALT;
`endif
      default: next_state = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control unit: state register plus gated enables around mc_ctrl_decode.
// MC_CTRL_HALT_EN builds the HALT state (left only by reset); otherwise HALT decodes as NOP.
//
// state | meaning
// IF    | fetch, IR write
// ID    | decode; J and NOP finish here
// EXE   | ALU op; BEQ finishes here
// MEM   | data memory; SW finishes here
// WB    | register write-back
// HALT  | stopped until reset (feature build only)
module mc_control_unit
  import mc_cpu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic [1:0]     PCSrc,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           RegWre,
  output logic           RegDst,
  output logic           MemRd,
  output logic           MemWr,
  output logic           DBDataSrc,
  output logic [2:0]     state,
  output logic           halted
);

  state_t state_q, state_d;
  logic   run;
  logic   pcwre, irwre, regwre, memrd, memwr;

  mc_ctrl_decode #(.OPW(OPW)) u_decode (
    .cur_state  (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .next_state (state_d),
    .pcwre      (pcwre),
    .irwre      (irwre),
    .pcsrc      (PCSrc),
    .alusrcb    (ALUSrcB),
    .aluop      (ALUOp),
    .regwre     (regwre),
    .regdst     (RegDst),
    .memrd      (memrd),
    .memwr      (memwr),
    .dbdatasrc  (DBDataSrc)
  );

  // run holds the FSM in IF, enables off, until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IF;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state_q <= state_d;
    end
  end

  assign PCWre  = run & pcwre;
  assign IRWre  = run & irwre;
  assign RegWre = run & regwre;
  assign MemRd  = run & memrd;
  assign MemWr  = run & memwr;
  assign state  = state_q;

`ifdef MC_CTRL_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
